// File: rtl/key_debounce_sync.sv
// Push-button conditioner: pad synchroniser plus counter-based debounce FSM with
// registered level and press/release strobes. Define KEY_DEBOUNCE_LONG_PRESS_EN for the long-hold strobe.
module key_debounce_sync #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int SYNC_STAGES       = 2,
    parameter bit ACTIVE_LOW_KEY    = 1'b1,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // state        | meaning
    // RELEASED     | key idle, waiting for a pressed sample
    // WAIT_PRESS   | pressed level seen, counting stable cycles
    // PRESSED      | press accepted, key_level = 1
    // WAIT_RELEASE | released level seen, counting stable cycles
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES
                                                                    : LONG_PRESS_CYCLES;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_check
        $error("key_debounce_sync: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   k;

    // Only sync_q[0] ever samples the asynchronous pad.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW_KEY}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign k = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_KEY;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(LONG_PRESS_CYCLES);
    logic armed_q;
    logic long_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            armed_q   <= 1'b1;
            long_q    <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            long_q    <= 1'b0;
`endif
            case (state_q)
                RELEASED: begin
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                    armed_q <= 1'b1;
`endif
                    if (k) begin
                        state_q <= WAIT_PRESS;
                        cnt_q   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!k) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!k) begin
                        state_q <= WAIT_RELEASE;
                        cnt_q   <= '0;
                    end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                    else begin
                        // Saturating hold timer; armed_q limits it to one strobe per press.
                        if (cnt_q != LP_SAT) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (cnt_q == LP_LAST && armed_q) begin
                            long_q  <= 1'b1;
                            armed_q <= 1'b0;
                        end
                    end
`endif
                end
                WAIT_RELEASE: begin
                    if (k) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= RELEASED;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    assign long_press    = long_q;
`else
    assign long_press    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync: expected output snapshots are queued per
// edge as stimulus is applied, then popped and checked when that edge arrives.
module tb_key_debounce_sync;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic key_raw = 1'b1;
    logic key_level, press_pulse, release_pulse, long_press;

    key_debounce_sync #(
        .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW_KEY(1'b1), .LONG_PRESS_CYCLES(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
        .key_level(key_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_press(long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        logic  lvl;
        logic  pr;
        logic  rl;
        logic  lp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   press_cnt = 0, release_cnt = 0, long_cnt = 0, both_cnt = 0;
    int   base;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expect_at(input int at, input string tag,
                             input logic lvl, input logic pr, input logic rl, input logic lp);
        exp_t e;
        e.cyc = at; e.tag = tag; e.lvl = lvl; e.pr = pr; e.rl = rl; e.lp = lp;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (press_pulse)   press_cnt++;
            if (release_pulse) release_cnt++;
            if (long_press)    long_cnt++;
            if (press_pulse && release_pulse) both_cnt++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk({e.tag, ".level"},   int'(key_level),     int'(e.lvl));
                chk({e.tag, ".press"},   int'(press_pulse),   int'(e.pr));
                chk({e.tag, ".release"}, int'(release_pulse), int'(e.rl));
                chk({e.tag, ".long"},    int'(long_press),    int'(e.lp));
            end
        end
    endtask

    task automatic clear_counts();
        press_cnt = 0; release_cnt = 0; long_cnt = 0;
    endtask

    initial begin
        // Reset held with pad idle (high)
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, "reset", 0, 0, 0, 0);
        step(3);

        reset_n = 1'b1;
        clear_counts();
        step(20);
        chk("idle.press_cnt", press_cnt, 0);
        chk("idle.release_cnt", release_cnt, 0);
        chk("idle.level", int'(key_level), 0);

        // Clean press, then long hold
        key_raw = 1'b0;
        base = cyc;
        clear_counts();
        expect_at(base + 6,  "press.e6",  0, 0, 0, 0);
        expect_at(base + 7,  "press.e7",  1, 1, 0, 0);
        expect_at(base + 8,  "press.e8",  1, 0, 0, 0);
        expect_at(base + 16, "press.e16", 1, 0, 0, 0);
        expect_at(base + 17, "press.e17", 1, 0, 0, LP_EN);
        expect_at(base + 18, "press.e18", 1, 0, 0, 0);
        step(38);
        chk("hold1.long_cnt", long_cnt, LP_EN ? 1 : 0);
        chk("hold1.press_cnt", press_cnt, 1);

        // Clean release
        key_raw = 1'b1;
        base = cyc;
        expect_at(base + 6, "rel.e6", 1, 0, 0, 0);
        expect_at(base + 7, "rel.e7", 0, 0, 1, 0);
        expect_at(base + 8, "rel.e8", 0, 0, 0, 0);
        step(8);

        // Bounces: 3 low / 3 high, five times
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            key_raw = 1'b0;
            step(3);
            key_raw = 1'b1;
            step(3);
        end
        chk("bounce.press_cnt", press_cnt, 0);
        chk("bounce.level", int'(key_level), 0);

        // Final stable low after the bounces
        key_raw = 1'b0;
        base = cyc;
        clear_counts();
        expect_at(base + 6, "bpress.e6", 0, 0, 0, 0);
        expect_at(base + 7, "bpress.e7", 1, 1, 0, 0);
        expect_at(base + 8, "bpress.e8", 1, 0, 0, 0);
        step(38);
        chk("hold2.long_cnt", long_cnt, LP_EN ? 1 : 0);

        // Two-cycle high glitch while pressed: no release, long not re-armed
        clear_counts();
        key_raw = 1'b1;
        step(2);
        key_raw = 1'b0;
        step(20);
        chk("glitch.release_cnt", release_cnt, 0);
        chk("glitch.level", int'(key_level), 1);
        chk("glitch.long_cnt", long_cnt, 0);

        key_raw = 1'b1;
        base = cyc;
        expect_at(base + 6, "rel2.e6", 1, 0, 0, 0);
        expect_at(base + 7, "rel2.e7", 0, 0, 1, 0);
        expect_at(base + 8, "rel2.e8", 0, 0, 0, 0);
        step(8);

        // Reset during WAIT_PRESS (cnt == 2) with key held
        key_raw = 1'b0;
        step(5);
        reset_n = 1'b0;
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, "midrst", 0, 0, 0, 0);
        step(3);
        reset_n = 1'b1;
        base = cyc;
        expect_at(base + 6, "rpress.e6", 0, 0, 0, 0);
        expect_at(base + 7, "rpress.e7", 1, 1, 0, 0);
        expect_at(base + 8, "rpress.e8", 1, 0, 0, 0);
        step(8);

        chk("queue_drained", q.size(), 0);
        chk("press_release_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
